// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder and decoder.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Field bundle as captured by the first pipeline stage.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } enc_fields_t;

endpackage

// File: rtl/imm_range_check.sv
// Combinational legality check of an immediate against its format and opcode.
module imm_range_check
  import rv_isa_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [31:0] imm,
  output logic        legal
);

  always_comb begin
    legal = 1'b0;
    case (fmt)
      FMT_R:        legal = 1'b1;
      FMT_I, FMT_S: legal = (imm[31:11] == {21{imm[11]}});
      FMT_B:        legal = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      FMT_U:        legal = (imm[11:0] == 12'd0);
      FMT_J:        legal = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      default:      legal = 1'b0;
    endcase
    // RV32I base encodings always end in 2'b11; anything else is compressed/invalid.
    if (opcode[1:0] != 2'b11) legal = 1'b0;
  end

endmodule

// File: rtl/ins_encoder.sv
// Two-stage RV32I instruction encoder: S1 captures fields + legality, S2 holds
// the packed word; valid/ready handshake on both sides with counters.
module ins_encoder
  import rv_isa_pkg::*;
#(
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] NOP_WORD  = RV_NOP
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [2:0]           IMM_FORMAT,
  input  logic [6:0]           OPCODE,
  input  logic [2:0]           FUNCT3,
  input  logic [6:0]           FUNCT7,
  input  logic [4:0]           RS1_ADDRESS,
  input  logic [4:0]           RS2_ADDRESS,
  input  logic [4:0]           RD_ADDRESS,
  input  logic [31:0]          IMMEDIATE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [31:0]          INSTRUCTION,
  output logic                 ENC_ERR,
  output logic [CNT_WIDTH-1:0] ENC_COUNT,
  output logic [CNT_WIDTH-1:0] ERR_COUNT
);

  enc_fields_t          in_f, s1_f;
  logic                 in_legal;
  logic                 s1_valid, s1_err;
  logic                 s2_valid, s2_err;
  logic [31:0]          s2_word, packed_word;
  logic                 s1_adv, s2_adv, out_fire;
  logic [CNT_WIDTH-1:0] enc_cnt, err_cnt;

  assign in_f = '{fmt: IMM_FORMAT, opcode: OPCODE, funct3: FUNCT3, funct7: FUNCT7,
                  rs1: RS1_ADDRESS, rs2: RS2_ADDRESS, rd: RD_ADDRESS, imm: IMMEDIATE};

  imm_range_check u_chk (
    .fmt    (IMM_FORMAT),
    .opcode (OPCODE),
    .imm    (IMMEDIATE),
    .legal  (in_legal)
  );

  // No skid buffer: input readiness ripples back combinationally from OUT_READY.
  assign s2_adv   = !s2_valid || OUT_READY;
  assign s1_adv   = !s1_valid || s2_adv;
  assign IN_READY = s1_adv;
  assign out_fire = s2_valid && OUT_READY;

  always_comb begin
    packed_word = NOP_WORD;
    case (s1_f.fmt)
      FMT_R: packed_word = {s1_f.funct7, s1_f.rs2, s1_f.rs1, s1_f.funct3, s1_f.rd, s1_f.opcode};
      FMT_I: packed_word = {s1_f.imm[11:0], s1_f.rs1, s1_f.funct3, s1_f.rd, s1_f.opcode};
      FMT_S: packed_word = {s1_f.imm[11:5], s1_f.rs2, s1_f.rs1, s1_f.funct3,
                            s1_f.imm[4:0], s1_f.opcode};
      FMT_B: packed_word = {s1_f.imm[12], s1_f.imm[10:5], s1_f.rs2, s1_f.rs1, s1_f.funct3,
                            s1_f.imm[4:1], s1_f.imm[11], s1_f.opcode};
      FMT_U: packed_word = {s1_f.imm[31:12], s1_f.rd, s1_f.opcode};
      FMT_J: packed_word = {s1_f.imm[20], s1_f.imm[10:1], s1_f.imm[11], s1_f.imm[19:12],
                            s1_f.rd, s1_f.opcode};
      default: packed_word = NOP_WORD;
    endcase
    if (s1_err) packed_word = NOP_WORD;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_f     <= '0;
    end else if (s1_adv) begin
      s1_valid <= IN_VALID;
      if (IN_VALID) begin
        s1_f   <= in_f;
        s1_err <= !in_legal;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_valid <= 1'b0;
      s2_word  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_word <= packed_word;
        s2_err  <= s1_err;
      end
    end
  end

  // Transfer count wraps; error count sticks at all-ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (out_fire) begin
      enc_cnt <= enc_cnt + CNT_WIDTH'(1);
      if (s2_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_WIDTH'(1);
    end
  end

  assign OUT_VALID   = s2_valid;
  assign INSTRUCTION = s2_word;
  assign ENC_ERR     = s2_err;
  assign ENC_COUNT   = enc_cnt;
  assign ERR_COUNT   = err_cnt;

endmodule

// File: tb/tb_ins_encoder.sv
// Scoreboard bench for ins_encoder: directed bundles push expected words, a
// negedge monitor pops and compares every output transfer.
module tb_ins_encoder;
  import rv_isa_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [2:0]  IMM_FORMAT = '0;
  logic [6:0]  OPCODE = '0;
  logic [2:0]  FUNCT3 = '0;
  logic [6:0]  FUNCT7 = '0;
  logic [4:0]  RS1_ADDRESS = '0;
  logic [4:0]  RS2_ADDRESS = '0;
  logic [4:0]  RD_ADDRESS = '0;
  logic [31:0] IMMEDIATE = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] INSTRUCTION;
  logic        ENC_ERR;
  logic [15:0] ENC_COUNT;
  logic [15:0] ERR_COUNT;

  always #5 CLK = ~CLK;

  ins_encoder #(.CNT_WIDTH(16), .NOP_WORD(32'h0000_0013)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IMM_FORMAT(IMM_FORMAT), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7(FUNCT7),
    .RS1_ADDRESS(RS1_ADDRESS), .RS2_ADDRESS(RS2_ADDRESS), .RD_ADDRESS(RD_ADDRESS),
    .IMMEDIATE(IMMEDIATE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .INSTRUCTION(INSTRUCTION), .ENC_ERR(ENC_ERR), .ENC_COUNT(ENC_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  typedef struct packed {logic [31:0] word; logic err;} exp_t;
  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  int          first_pop = 0, last_pop = 0, n_pop = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_w;
  logic        held_e;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (RST) held_v = 1'b0;
    else if (OUT_VALID) begin
      if (held_v) begin
        check("hold_word", INSTRUCTION, held_w);
        check("hold_err", {31'd0, ENC_ERR}, {31'd0, held_e});
      end
      if (OUT_READY) begin
        held_v = 1'b0;
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got %h want none", INSTRUCTION);
        end else begin
          mon_e = q.pop_front();
          check("word", INSTRUCTION, mon_e.word);
          check("enc_err", {31'd0, ENC_ERR}, {31'd0, mon_e.err});
        end
        if (n_pop == 0) first_pop = cyc;
        last_pop = cyc;
        n_pop++;
      end else begin
        held_v = 1'b1; held_w = INSTRUCTION; held_e = ENC_ERR;
      end
    end else held_v = 1'b0;
  end

  // Called right after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm,
                      input logic [31:0] word, input logic err);
    bit ok = 1'b0;
    IMM_FORMAT = fmt; OPCODE = op; FUNCT3 = f3; FUNCT7 = f7;
    RS1_ADDRESS = rs1; RS2_ADDRESS = rs2; RD_ADDRESS = rd; IMMEDIATE = imm;
    IN_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (IN_READY) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got IN_READY=0 want 1 within 100 cycles");
    end else q.push_back('{word: word, err: err});
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge CLK);
    #1;
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    do_reset();
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_instruction", INSTRUCTION, 32'd0);
    check("rst_enc_err", {31'd0, ENC_ERR}, 32'd0);
    check("rst_enc_count", {16'd0, ENC_COUNT}, 32'd0);
    check("rst_err_count", {16'd0, ERR_COUNT}, 32'd0);
    check("rst_in_ready", {31'd0, IN_READY}, 32'd1);

    // add x3,x1,x2 and its latency
    send(FMT_R, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
    @(negedge CLK); check("lat_edge1_valid", {31'd0, OUT_VALID}, 32'd0);
    @(negedge CLK); check("lat_edge2_valid", {31'd0, OUT_VALID}, 32'd1);
    drain();

    // Legal formats, back to back
    send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
    send(FMT_B, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8,         32'h00208463, 1'b0);
    send(FMT_U, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h123452B7, 1'b0);
    send(FMT_J, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 32'h001000EF, 1'b0);
    send(FMT_S, 7'h23, 3'd2, 7'h00, 5'd2, 5'd3, 5'd0, 32'hFFFF_FFFC, 32'hFE312E23, 1'b0);
    send(FMT_R, 7'h33, 3'd0, 7'h20, 5'd6, 5'd7, 5'd5, 32'd0,         32'h407302B3, 1'b0);
    send(FMT_B, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 32'hFE208CE3, 1'b0);
    send(FMT_J, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDFF06F, 1'b0);
    send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFF_F800, 32'h80000093, 1'b0);
    send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2047,      32'h7FF00093, 1'b0);
    send(FMT_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000, 32'h80000063, 1'b0);
    drain();
    check("legal_enc_count", {16'd0, ENC_COUNT}, 32'd12);
    check("legal_err_count", {16'd0, ERR_COUNT}, 32'd0);

    // Illegal bundles become NOPs with ENC_ERR
    send(FMT_B, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd7,    32'h00000013, 1'b1);
    send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048, 32'h00000013, 1'b1);
    send(3'd6,  7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd0,    32'h00000013, 1'b1);
    drain();
    check("err3_err_count", {16'd0, ERR_COUNT}, 32'd3);
    send(3'd7,  7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd0,          32'h00000013, 1'b1);
    send(FMT_I, 7'h10, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd0,          32'h00000013, 1'b1);
    send(FMT_U, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5001,  32'h00000013, 1'b1);
    send(FMT_J, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd1,          32'h00000013, 1'b1);
    send(FMT_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4096,       32'h00000013, 1'b1);
    send(FMT_J, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h0010_0000,  32'h00000013, 1'b1);
    drain();
    check("err9_err_count", {16'd0, ERR_COUNT}, 32'd9);
    check("err9_enc_count", {16'd0, ENC_COUNT}, 32'd21);

    // Backpressure: two bundles fill the pipe, the third is refused
    OUT_READY = 1'b0;
    fork
      begin
        send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd1, 32'h00100093, 1'b0);
        send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 32'd2, 32'h00200113, 1'b0);
        send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 32'd3, 32'h00300193, 1'b0);
      end
      begin
        repeat (3) @(negedge CLK);
        check("bp_in_ready", {31'd0, IN_READY}, 32'd0);
        check("bp_out_valid", {31'd0, OUT_VALID}, 32'd1);
        check("bp_head_word", INSTRUCTION, 32'h00100093);
        repeat (2) @(posedge CLK);
        #1 OUT_READY = 1'b1;
      end
    join
    drain();
    check("bp_enc_count", {16'd0, ENC_COUNT}, 32'd24);

    // Streaming 100 back-to-back
    do_reset();
    n_pop = 0;
    for (int i = 0; i < 100; i++) begin
      w = {12'(i), 5'd0, 3'd0, 5'(i % 32), 7'h13};
      send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'(i % 32), 32'(i), w, 1'b0);
    end
    drain();
    check("stream_pops", 32'(n_pop), 32'd100);
    check("stream_span", 32'(last_pop - first_pop), 32'd99);
    check("stream_enc_count", {16'd0, ENC_COUNT}, 32'd100);

    // Counter wrap and error saturation
    do_reset();
    for (int i = 0; i < 65535; i++)
      send(3'd7, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'h00000013, 1'b1);
    drain();
    check("pre_wrap_enc_count", {16'd0, ENC_COUNT}, 32'h0000FFFF);
    check("pre_wrap_err_count", {16'd0, ERR_COUNT}, 32'h0000FFFF);
    send(3'd7, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'h00000013, 1'b1);
    drain();
    check("wrap_enc_count", {16'd0, ENC_COUNT}, 32'd0);
    check("sat_err_count", {16'd0, ERR_COUNT}, 32'h0000FFFF);

    // Reset with two bundles in flight
    send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd1, 32'h00100093, 1'b0);
    send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 32'd2, 32'h00200113, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    q.delete();
    check("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("midrst_enc_count", {16'd0, ENC_COUNT}, 32'd0);
    check("midrst_err_count", {16'd0, ERR_COUNT}, 32'd0);
    check("midrst_in_ready", {31'd0, IN_READY}, 32'd1);
    @(negedge CLK);
    check("midrst_no_leak", {31'd0, OUT_VALID}, 32'd0);
    @(posedge CLK); #1;
    send(FMT_I, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 32'd3, 32'h00300193, 1'b0);
    drain();
    check("post_rst_enc_count", {16'd0, ENC_COUNT}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
